// File: rtl/keypad_hex_entry.sv
// Scans a 4x4 active-low keypad, debounces presses and shifts accepted hex digits into a 32-bit entry register.
// Latency: stable press to key_valid within 4*SCAN_DIV + DEBOUNCE_CNT + 3 cycles; no backpressure, one pulse per press.
module keypad_hex_entry #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic [31:0] num,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [3:0]  digit_cnt
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    col_s1_q, col_s2_q;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]    cap_col_q, cap_col_d;
  logic [31:0]   num_q, num_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic [3:0]    digit_q, digit_d;

  logic          col_ok;
  logic [1:0]    col_idx;
  logic [3:0]    code;
  logic          accept;

  // Exactly one low column is a real key; several low columns are ghosting and ignored.
  assign col_ok = ($countones(~col_s2_q) == 1);

  always_comb begin
    col_idx = 2'd0;
    case (cap_col_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  assign code = {row_idx_q, col_idx};

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    scan_cnt_d = scan_cnt_q;
    db_cnt_d   = db_cnt_q;
    cap_col_d  = cap_col_q;
    accept     = 1'b0;
    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (col_ok) begin
            state_d   = DEBOUNCE;
            cap_col_d = col_s2_q;
            db_cnt_d  = '0;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SW'(1);
        end
      end
      DEBOUNCE: begin
        if (col_s2_q != cap_col_q) begin
          state_d    = SCAN;
          row_idx_d  = row_idx_q + 2'd1;
          scan_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          accept   = 1'b1;
          state_d  = RELEASE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      RELEASE: begin
        // Any key still down restarts the idle window, so held keys never auto-repeat.
        if (col_s2_q != 4'b1111) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = SCAN;
          row_idx_d  = row_idx_q + 2'd1;
          scan_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // clr takes priority over a coinciding accept; the key is still consumed by the FSM.
  always_comb begin
    valid_d = accept && !clr;
    code_d  = (accept && !clr) ? code : code_q;
    num_d   = num_q;
    digit_d = digit_q;
    if (clr) begin
      num_d   = '0;
      digit_d = '0;
    end else if (accept) begin
      num_d   = {num_q[27:0], code};
      digit_d = (digit_q == 4'd8) ? 4'd8 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      col_s1_q   <= 4'b1111;
      col_s2_q   <= 4'b1111;
      row_idx_q  <= 2'd0;
      scan_cnt_q <= '0;
      db_cnt_q   <= '0;
      cap_col_q  <= 4'b1111;
      num_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      digit_q    <= '0;
    end else begin
      state_q    <= state_d;
      col_s1_q   <= col;
      col_s2_q   <= col_s1_q;
      row_idx_q  <= row_idx_d;
      scan_cnt_q <= scan_cnt_d;
      db_cnt_q   <= db_cnt_d;
      cap_col_q  <= cap_col_d;
      num_q      <= num_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      digit_q    <= digit_d;
    end
  end

  assign row       = ~(4'b0001 << row_idx_q);
  assign num       = num_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign digit_cnt = digit_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Directed bench for keypad_hex_entry with a behavioural 4x4 keypad (SCAN_DIV=4, DEBOUNCE_CNT=8).
module tb_keypad_hex_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        clr;
  logic [31:0] num;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [3:0]  digit_cnt;

  logic [15:0] keys_down;
  logic        ovr_en;
  logic [3:0]  ovr_col;
  logic [3:0]  col_model;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int pulse_cnt = 0;
  logic [3:0] last_code = 4'h0;
  int prev;

  keypad_hex_entry #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .clr(clr),
    .num(num), .key_code(key_code), .key_valid(key_valid), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  // A pressed key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col_model = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[4*r+c] && !row[r]) col_model[c] = 1'b0;
  end
  assign col = ovr_en ? ovr_col : col_model;

  always @(negedge clk) begin
    if (key_valid) begin
      pulse_cnt <= pulse_cnt + 1;
      last_code <= key_code;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_row(input logic [3:0] exp, input string tag);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (row !== exp && n < 40);
    check(tag, 32'(row), 32'(exp));
  endtask

  task automatic press_key(input int code);
    int p = pulse_cnt;
    int n = 0;
    keys_down = 16'(1) << code;
    while (pulse_cnt == p && n < 60) begin
      tick(1);
      n++;
    end
    check("press_pulse", 32'(pulse_cnt), 32'(p + 1));
    check("press_code", 32'(last_code), 32'(code));
    keys_down = '0;
    tick(15);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; keys_down = '0;
    ovr_en = 1'b1; ovr_col = 4'b0111;
    tick(3);
    check("rst_row", 32'(row), 32'h0000_000E);
    check("rst_num", num, 32'h0);
    check("rst_digits", 32'(digit_cnt), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_pulses", 32'(pulse_cnt), 32'h0);

    rst_n = 1'b1; ovr_en = 1'b0; ovr_col = 4'b1111;
    tick(3); check("scan_row0_hold", 32'(row), 32'h0000_000E);
    tick(1); check("scan_row1", 32'(row), 32'h0000_000D);
    tick(4); check("scan_row2", 32'(row), 32'h0000_000B);
    tick(4); check("scan_row3", 32'(row), 32'h0000_0007);
    tick(4); check("scan_wrap", 32'(row), 32'h0000_000E);

    // r2c3 held for 200 cycles
    keys_down = 16'(1) << 11;
    tick(200);
    check("hold_pulses", 32'(pulse_cnt), 32'd1);
    check("hold_code", 32'(last_code), 32'h0000_000B);
    check("hold_num", num, 32'h0000_000B);
    check("hold_digits", 32'(digit_cnt), 32'd1);
    check("hold_row", 32'(row), 32'h0000_000B);
    keys_down = '0;
    tick(9); check("release_row_held", 32'(row), 32'h0000_000B);
    tick(1); check("release_row_next", 32'(row), 32'h0000_0007);

    // r1c0 bounces: 5 cycles down, 2 up, then stable
    wait_row(4'b1101, "bounce_align");
    prev = pulse_cnt;
    keys_down = 16'(1) << 4;
    tick(5);
    keys_down = '0;
    tick(2);
    check("bounce_no_pulse", 32'(pulse_cnt), 32'(prev));
    check("bounce_row_held", 32'(row), 32'h0000_000D);
    keys_down = 16'(1) << 4;
    tick(1);
    check("bounce_abort_row", 32'(row), 32'h0000_000B);
    tick(100);
    check("bounce_pulses", 32'(pulse_cnt), 32'(prev + 1));
    check("bounce_code", 32'(last_code), 32'h0000_0004);
    check("bounce_num", num, 32'h0000_00B4);
    keys_down = '0;
    tick(15);

    for (int k = 1; k <= 9; k++) press_key(k);
    check("seq_num", num, 32'h2345_6789);
    check("seq_digits_sat", 32'(digit_cnt), 32'd8);

    // Ghost: r0c2 and r0c3 together read as 0011 on row 0
    wait_row(4'b1110, "ghost_align");
    prev = pulse_cnt;
    keys_down = (16'(1) << 2) | (16'(1) << 3);
    tick(4);
    check("ghost_rotates", 32'(row), 32'h0000_000D);
    tick(96);
    check("ghost_no_pulse", 32'(pulse_cnt), 32'(prev));
    check("ghost_num", num, 32'h2345_6789);
    keys_down = '0;
    tick(4);

    clr = 1'b1; tick(1); clr = 1'b0;
    check("clr_num", num, 32'h0);
    check("clr_digits", 32'(digit_cnt), 32'h0);
    press_key(1);
    press_key(2);
    check("pre_num", num, 32'h0000_0012);
    check("pre_digits", 32'(digit_cnt), 32'd2);

    // Key F on row 3: accepting edge is the 12th after the slot starts
    wait_row(4'b0111, "clr_align");
    prev = pulse_cnt;
    keys_down = 16'(1) << 15;
    tick(11);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("clracc_valid", 32'(key_valid), 32'h0);
    check("clracc_num", num, 32'h0);
    check("clracc_digits", 32'(digit_cnt), 32'h0);
    check("clracc_row", 32'(row), 32'h0000_0007);
    tick(50);
    check("clracc_no_pulse", 32'(pulse_cnt), 32'(prev));
    check("clracc_num_hold", num, 32'h0);
    check("clracc_row_hold", 32'(row), 32'h0000_0007);
    keys_down = '0;
    tick(15);
    press_key(5);
    check("post_num", num, 32'h0000_0005);
    check("post_digits", 32'(digit_cnt), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
